hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard controller. Generates the stall into the ID/EX buffer, which injects a NOP (ADD r0,r0,r0) on the next edge.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/div_busy_tracker.sv | 71 +++++++
 rtl/hazard_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//  Shared types and instruction-field constants for the pipeline hazard
//  controller (hazard_stall_ctrl) and its divider busy tracker.
//  No ports. Configuration macro used by the top: HAZARD_PERF_EN.
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } div_state_e;

   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] FN_DIV     = 6'b011010;
   localparam logic [5:0] FN_DIVU    = 6'b011011;
   localparam logic [5:0] FN_MFHI    = 6'b010000;
   localparam logic [5:0] FN_MFLO    = 6'b010010;
   // Funct of the bubble (ADD r0,r0,r0) injected by the ID/EX stall.
   localparam logic [5:0] FN_NOP_ADD = 6'b100000;

   function automatic logic is_div(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_RTYPE) && ((fn == FN_DIV) || (fn == FN_DIVU));
   endfunction

   function automatic logic is_hilo_rd(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_RTYPE) && ((fn == FN_MFHI) || (fn == FN_MFLO));
   endfunction

endpackage

// File: rtl/div_busy_tracker.sv
// -----------------------------------------------------------------------------
// div_busy_tracker
//  Tracks whether HI/LO are still being produced by the divider. Goes BUSY
//  when a DIV/DIVU is in EX and returns to IDLE exactly DIV_LATENCY cycles
//  after the most recent one.
//  Ports:
//   CLK          in  clock, rising edge
//   RST_N        in  asynchronous reset, active low
//   i_div_in_ex  in  DIV/DIVU currently in EX
//   o_busy       out HI/LO not yet valid (state == BUSY)
// -----------------------------------------------------------------------------
module div_busy_tracker
   import hazard_pkg::*;
#(
   parameter int DIV_LATENCY = 32
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic i_div_in_ex,
   output logic o_busy
);

   localparam int CNT_BITS = $clog2(DIV_LATENCY + 1);
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(DIV_LATENCY);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

   div_state_e          r_state, w_state_nxt;
   logic [CNT_BITS-1:0] r_cnt,   w_cnt_nxt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (i_div_in_ex) begin
               w_cnt_nxt   = CNT_LOAD;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            // A newer divide restarts the wait; otherwise count down and
            // leave on the last cycle of the latency window.
            if (i_div_in_ex) begin
               w_cnt_nxt = CNT_LOAD;
            end else if (r_cnt == CNT_ONE) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_busy = (r_state == BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//  Pipeline hazard controller beside the ID stage. Produces the ID/EX bubble
//  (stall), PC and IF/ID load enables and the IF/ID flush. Handles load-use,
//  taken branch/jump redirect from EX and HI/LO reads while the divider is
//  still busy. Outputs are combinational (same-cycle response).
//  Optional macro HAZARD_PERF_EN: enables the saturating performance
//  counters; otherwise stall_cycles / flush_count are tied to zero.
//  Ports:
//   CLK, RST_N                       clock / async active-low reset
//   id_Read1, id_Read2               rs / rt of ID instruction
//   id_Uses1, id_Uses2               ID instruction reads rs / rt
//   id_Opcode, id_Funct              ID instruction opcode / funct
//   ex_MemRead                       EX instruction is a load
//   ex_Reg_Write_addr                EX destination register
//   ex_Opcode, ex_Funct              EX instruction opcode / funct
//   ex_redirect                      EX resolved a taken branch/jump
//   stall                            ID/EX loads NOP at next edge
//   PC_write, IFID_write             PC / IF/ID load enables
//   IFID_flush                       IF/ID loads NOP at next edge
//   stall_cycles, flush_count        performance counters
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int DIV_LATENCY = 32,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [4:0]       id_Read1,
   input  logic [4:0]       id_Read2,
   input  logic             id_Uses1,
   input  logic             id_Uses2,
   input  logic [5:0]       id_Opcode,
   input  logic [5:0]       id_Funct,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_Reg_Write_addr,
   input  logic [5:0]       ex_Opcode,
   input  logic [5:0]       ex_Funct,
   input  logic             ex_redirect,
   output logic             stall,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   logic w_load_use;
   logic w_div_in_ex;
   logic w_hilo_rd;
   logic w_div_busy;
   logic w_hilo_wait;

   // r0 is never a real destination, so a load into r0 cannot create a hazard.
   assign w_load_use = ex_MemRead && (ex_Reg_Write_addr != 5'd0) &&
                       ((id_Uses1 && (id_Read1 == ex_Reg_Write_addr)) ||
                        (id_Uses2 && (id_Read2 == ex_Reg_Write_addr)));

   assign w_div_in_ex = is_div(ex_Opcode, ex_Funct);
   assign w_hilo_rd   = is_hilo_rd(id_Opcode, id_Funct);

   // Redirects do not touch the tracker: the divide in EX is older than the
   // branch and still commits.
   div_busy_tracker #(
      .DIV_LATENCY (DIV_LATENCY)
   ) u_div_busy (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .i_div_in_ex (w_div_in_ex),
      .o_busy      (w_div_busy)
   );

   assign w_hilo_wait = w_hilo_rd && (w_div_busy || w_div_in_ex);

   always_comb begin
      stall      = 1'b0;
      IFID_flush = 1'b0;
      PC_write   = 1'b1;
      IFID_write = 1'b1;
      if (!RST_N) begin
         stall      = 1'b1;
         IFID_flush = 1'b1;
         PC_write   = 1'b0;
         IFID_write = 1'b0;
      end else if (ex_redirect) begin
         // Squash the wrong-path instructions in IF/ID and ID; PC takes target.
         stall      = 1'b1;
         IFID_flush = 1'b1;
      end else if (w_load_use || w_hilo_wait) begin
         // Hold IF/ID and PC, send a bubble into EX.
         stall      = 1'b1;
         PC_write   = 1'b0;
         IFID_write = 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (stall && !ex_redirect && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         if (ex_redirect && (r_flush_count != '1))
            r_flush_count <= r_flush_count + 1'b1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

   localparam int DIV_LAT = 4;
   localparam int CW      = 4;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [4:0]    id_Read1, id_Read2, ex_Reg_Write_addr;
   logic          id_Uses1, id_Uses2, ex_MemRead, ex_redirect;
   logic [5:0]    id_Opcode, id_Funct, ex_Opcode, ex_Funct;
   logic          stall, PC_write, IFID_write, IFID_flush;
   logic [CW-1:0] stall_cycles, flush_count;

   hazard_stall_ctrl #(.DIV_LATENCY(DIV_LAT), .CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .id_Read1(id_Read1), .id_Read2(id_Read2),
      .id_Uses1(id_Uses1), .id_Uses2(id_Uses2),
      .id_Opcode(id_Opcode), .id_Funct(id_Funct),
      .ex_MemRead(ex_MemRead), .ex_Reg_Write_addr(ex_Reg_Write_addr),
      .ex_Opcode(ex_Opcode), .ex_Funct(ex_Funct),
      .ex_redirect(ex_redirect),
      .stall(stall), .PC_write(PC_write), .IFID_write(IFID_write),
      .IFID_flush(IFID_flush),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 CLK = ~CLK;

   localparam logic [5:0] F_ADD = 6'b100000, F_DIV = 6'b011010, F_DIVU = 6'b011011;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_SUB = 6'b100010;
   localparam logic [5:0] O_LW = 6'b100011, O_BEQ = 6'b000100;

   typedef struct {
      logic [4:0] r1, r2;
      logic       u1, u2;
      logic [5:0] idop, idfn;
      logic       memrd;
      logic [4:0] exwa;
      logic [5:0] exop, exfn;
      logic       redir;
      logic       es, epc, eif, efl;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // Reference model state: cycle index and when the last divide was in EX.
   int cyc = 0;
   int last_div = 0;
   bit have_div = 0;
   int m_sc = 0, m_fc = 0;
   localparam int CMAX = (1 << CW) - 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int r1, r2, u1, u2, input logic [5:0] idop, idfn,
                               input int memrd, exwa, input logic [5:0] exop, exfn,
                               input int redir, es, epc, eif, efl);
      vec_t v;
      v.r1 = 5'(r1); v.r2 = 5'(r2); v.u1 = u1[0]; v.u2 = u2[0];
      v.idop = idop; v.idfn = idfn; v.memrd = memrd[0]; v.exwa = 5'(exwa);
      v.exop = exop; v.exfn = exfn; v.redir = redir[0];
      v.es = es[0]; v.epc = epc[0]; v.eif = eif[0]; v.efl = efl[0];
      return v;
   endfunction

   task automatic model_out(input vec_t v, output bit s, output bit p, output bit w, output bit f);
      bit lu, dnow, rd, busy;
      lu   = v.memrd && v.exwa != 0 &&
             ((v.u1 && v.r1 == v.exwa) || (v.u2 && v.r2 == v.exwa));
      dnow = v.exop == 0 && (v.exfn == F_DIV || v.exfn == F_DIVU);
      rd   = v.idop == 0 && (v.idfn == F_MFHI || v.idfn == F_MFLO);
      busy = have_div && (cyc - last_div >= 1) && (cyc - last_div <= DIV_LAT);
      if (v.redir)                   begin s = 1; p = 1; w = 1; f = 1; end
      else if (lu || (rd && (busy || dnow))) begin s = 1; p = 0; w = 0; f = 0; end
      else                           begin s = 0; p = 1; w = 1; f = 0; end
   endtask

   task automatic model_reset();
      have_div = 0; m_sc = 0; m_fc = 0;
   endtask

   task automatic apply(input vec_t v);
      id_Read1 = v.r1; id_Read2 = v.r2; id_Uses1 = v.u1; id_Uses2 = v.u2;
      id_Opcode = v.idop; id_Funct = v.idfn; ex_MemRead = v.memrd;
      ex_Reg_Write_addr = v.exwa; ex_Opcode = v.exop; ex_Funct = v.exfn;
      ex_redirect = v.redir;
   endtask

   // One clock: drive at negedge, check #1 later, then advance model at posedge.
   task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
      bit s, p, w, f;
      @(negedge CLK);
      apply(v);
      #1;
      model_out(v, s, p, w, f);
      if (use_tab) begin s = v.es; p = v.epc; w = v.eif; f = v.efl; end
      check({tag, ".stall"},      int'(stall),      int'(s));
      check({tag, ".PC_write"},   int'(PC_write),   int'(p));
      check({tag, ".IFID_write"}, int'(IFID_write), int'(w));
      check({tag, ".IFID_flush"}, int'(IFID_flush), int'(f));
      check({tag, ".stall_cycles"}, int'(stall_cycles), PERF ? m_sc : 0);
      check({tag, ".flush_count"},  int'(flush_count),  PERF ? m_fc : 0);
      @(posedge CLK);
      if (v.exop == 0 && (v.exfn == F_DIV || v.exfn == F_DIVU)) begin
         have_div = 1; last_div = cyc;
      end
      if (s && !v.redir && m_sc < CMAX) m_sc++;
      if (v.redir && m_fc < CMAX) m_fc++;
      cyc++;
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      model_reset();
      check({tag, ".rst_stall"},  int'(stall),      1);
      check({tag, ".rst_pcw"},    int'(PC_write),   0);
      check({tag, ".rst_ifw"},    int'(IFID_write), 0);
      check({tag, ".rst_flush"},  int'(IFID_flush), 1);
      check({tag, ".rst_sc"},     int'(stall_cycles), 0);
      check({tag, ".rst_fc"},     int'(flush_count),  0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   vec_t tab[$];
   vec_t v;

   initial begin
      apply(mk(0,0,0,0,6'd0,F_ADD,0,0,6'd0,F_ADD,0,0,0,0,0));
      do_reset("init");

      // Directed single-cycle vectors, all starting with the divider idle.
      //          r1 r2 u1 u2 idop  idfn   mr wa exop  exfn   rd  s pc if fl
      tab.push_back(mk(5, 1, 1, 1, 6'd0, F_ADD, 1, 5, O_LW, 6'd0, 0, 1,0,0,0)); // lw r5 -> add r6,r5,r1
      tab.push_back(mk(0, 0, 1, 1, 6'd0, F_ADD, 1, 0, O_LW, 6'd0, 0, 0,1,1,0)); // lw r0
      tab.push_back(mk(3, 5, 1, 0, 6'd0, F_ADD, 1, 5, O_LW, 6'd0, 0, 0,1,1,0)); // rt=5 unused
      tab.push_back(mk(3, 5, 1, 1, 6'd0, F_ADD, 1, 5, O_LW, 6'd0, 0, 1,0,0,0)); // rt=5 used
      tab.push_back(mk(5, 2, 0, 1, 6'd0, F_ADD, 1, 5, O_LW, 6'd0, 0, 0,1,1,0)); // rs=5 unused
      tab.push_back(mk(5, 5, 1, 1, 6'd0, F_ADD, 0, 5, 6'd0, F_ADD, 0, 0,1,1,0)); // not a load
      tab.push_back(mk(5, 1, 1, 1, 6'd0, F_ADD, 1, 5, O_LW, 6'd0, 1, 1,1,1,1)); // redirect + load_use
      tab.push_back(mk(1, 2, 1, 1, 6'd0, F_ADD, 0, 3, O_BEQ,6'd0, 1, 1,1,1,1)); // redirect alone
      tab.push_back(mk(0, 0, 0, 0, 6'd0, F_MFHI,0, 3, 6'd0, F_ADD, 0, 0,1,1,0)); // MFHI, idle
      tab.push_back(mk(0, 0, 0, 0, 6'd0, F_MFLO,0, 3, 6'd0, F_SUB, 0, 0,1,1,0)); // MFLO, idle
      tab.push_back(mk(0, 0, 0, 0, 6'd0, F_MFHI,0, 3, 6'd0, F_DIVU,0, 1,0,0,0)); // MFHI with DIVU in EX
      for (int i = 0; i < tab.size(); i++)
         run_cycle(tab[i], 1'b1, $sformatf("tab%0d", i));

      // Load-use stalls one cycle: the bubble (ADD) follows the load.
      do_reset("lu");
      run_cycle(mk(5,1,1,1,6'd0,F_ADD,1,5,O_LW,6'd0,0, 1,0,0,0), 1'b1, "lu.t0");
      run_cycle(mk(5,1,1,1,6'd0,F_ADD,0,0,6'd0,F_ADD,0, 0,1,1,0), 1'b1, "lu.t1");

      // DIV at t, MFLO waiting in ID: stall t..t+4, free at t+5.
      do_reset("div1");
      for (int k = 0; k <= 5; k++) begin
         v = mk(0,0,0,0,6'd0,F_MFLO,0,0,6'd0,(k == 0) ? F_DIV : F_ADD,0,
                (k <= 4), (k > 4), (k > 4), 0);
         run_cycle(v, 1'b1, $sformatf("div1.t%0d", k));
      end

      // Second DIV at t+2 while busy: MFHI held through t+6, free at t+7.
      do_reset("div2");
      for (int k = 0; k <= 7; k++) begin
         v = mk(0,0,0,0,6'd0,F_MFHI,0,0,6'd0,(k == 0 || k == 2) ? F_DIV : F_ADD,0,
                (k <= 6), (k > 6), (k > 6), 0);
         run_cycle(v, 1'b1, $sformatf("div2.t%0d", k));
      end

      // Same start, then async reset mid-wait at t+3.
      do_reset("div3");
      for (int k = 0; k <= 2; k++) begin
         v = mk(0,0,0,0,6'd0,F_MFHI,0,0,6'd0,(k == 0 || k == 2) ? F_DIV : F_ADD,0,1,0,0,0);
         run_cycle(v, 1'b1, $sformatf("div3.t%0d", k));
      end
      @(negedge CLK);
      apply(mk(0,0,0,0,6'd0,F_MFHI,0,0,6'd0,F_ADD,0,0,0,0,0));
      #1;
      check("div3.t3.stall", int'(stall), 1);
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      check("div3.rst.stall", int'(stall), 1);
      check("div3.rst.pcw",   int'(PC_write), 0);
      check("div3.rst.ifw",   int'(IFID_write), 0);
      check("div3.rst.flush", int'(IFID_flush), 1);
      check("div3.rst.sc",    int'(stall_cycles), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      // Tracker back to IDLE: the waiting MFHI proceeds.
      run_cycle(mk(0,0,0,0,6'd0,F_MFHI,0,0,6'd0,F_ADD,0, 0,1,1,0), 1'b1, "div3.after");

      // Randomized traffic against the model.
      do_reset("rnd");
      for (int i = 0; i < 2000; i++) begin
         int pick;
         v.r1 = 5'($urandom_range(0, 3));
         v.r2 = 5'($urandom_range(0, 3));
         v.u1 = 1'($urandom_range(0, 1));
         v.u2 = 1'($urandom_range(0, 1));
         pick = $urandom_range(0, 9);
         v.idop = (pick == 9) ? O_LW : 6'd0;
         v.idfn = (pick < 2) ? F_MFHI : (pick < 4) ? F_MFLO : F_ADD;
         v.memrd = ($urandom_range(0, 9) < 3);
         v.exwa  = 5'($urandom_range(0, 3));
         pick = $urandom_range(0, 24);
         v.exop = v.memrd ? O_LW : 6'd0;
         v.exfn = v.memrd ? 6'd0 : (pick == 0) ? F_DIV : (pick == 1) ? F_DIVU :
                  (pick == 2) ? F_MFLO : F_ADD;
         v.redir = ($urandom_range(0, 9) == 0);
         v.es = 0; v.epc = 0; v.eif = 0; v.efl = 0;
         run_cycle(v, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
